// File: rtl/pixel_in_buffer.sv
// Ping-pong input frame buffer feeding the layer control unit: fills one bank from a
// valid/ready pixel stream while the other bank is read by the datapath.
module pixel_in_buffer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 112,
    parameter int unsigned ADDR_W = 7
) (
    input  logic              clk,
    input  logic              GlobalReset_n,
    input  logic [DATA_W-1:0] Pixel_In,
    input  logic              Pixel_In_Valid,
    output logic              Pixel_In_Ready,
    input  logic              Compute_Done,
    input  logic [ADDR_W-1:0] PixelX_Select,
    output logic [DATA_W-1:0] Pixel_Out,
    output logic              Input_Valid,
    output logic              Compute_Busy,
    output logic              Bank_Sel
);

    localparam int unsigned       BANKS     = 2;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        LD_FILL = 1'b0,
        LD_FULL = 1'b1
    } load_state_t;

    typedef enum logic {
        CP_IDLE = 1'b0,
        CP_BUSY = 1'b1
    } comp_state_t;

    load_state_t       r_load_state;
    load_state_t       w_load_state_nxt;
    comp_state_t       r_comp_state;
    comp_state_t       w_comp_state_nxt;
    logic [ADDR_W-1:0] r_count;
    logic [ADDR_W-1:0] w_count_nxt;
    logic              r_bank_sel;
    logic              w_bank_sel_nxt;
    logic              r_input_valid;
    logic              w_input_valid_nxt;

    logic [DATA_W-1:0] r_mem [BANKS][DEPTH];

    logic              w_accept;
    logic              w_swap;
    logic              w_rd_bank;
    logic              w_sel_in_range;

    assign w_accept = Pixel_In_Valid && (r_load_state == LD_FILL);
    // A complete frame moves to the compute side once that side is free or being released.
    assign w_swap   = (r_load_state == LD_FULL) &&
                      ((r_comp_state == CP_IDLE) || Compute_Done);

    // State and control registers
    always_ff @(posedge clk or negedge GlobalReset_n) begin
        if (!GlobalReset_n) begin
            r_load_state  <= LD_FILL;
            r_comp_state  <= CP_IDLE;
            r_count       <= '0;
            r_bank_sel    <= 1'b0;
            r_input_valid <= 1'b0;
        end else begin
            r_load_state  <= w_load_state_nxt;
            r_comp_state  <= w_comp_state_nxt;
            r_count       <= w_count_nxt;
            r_bank_sel    <= w_bank_sel_nxt;
            r_input_valid <= w_input_valid_nxt;
        end
    end

    // Next-state logic for both FSMs; swap and accept are mutually exclusive
    always_comb begin
        w_load_state_nxt  = r_load_state;
        w_comp_state_nxt  = r_comp_state;
        w_count_nxt       = r_count;
        w_bank_sel_nxt    = r_bank_sel;
        w_input_valid_nxt = 1'b0;

        if (w_swap) begin
            w_load_state_nxt  = LD_FILL;
            w_comp_state_nxt  = CP_BUSY;
            w_bank_sel_nxt    = ~r_bank_sel;
            w_count_nxt       = '0;
            w_input_valid_nxt = 1'b1;
        end else begin
            if (w_accept) begin
                if (r_count == LAST_ADDR) begin
                    w_load_state_nxt = LD_FULL;
                end else begin
                    w_count_nxt = r_count + ADDR_W'(1);
                end
            end
            if ((r_comp_state == CP_BUSY) && Compute_Done) begin
                w_comp_state_nxt = CP_IDLE;
            end
        end
    end

    // Frame storage; only the load bank is ever written
    always_ff @(posedge clk or negedge GlobalReset_n) begin
        if (!GlobalReset_n) begin
            for (int unsigned b = 0; b < BANKS; b++) begin
                for (int unsigned a = 0; a < DEPTH; a++) begin
                    r_mem[b][a] <= '0;
                end
            end
        end else if (w_accept) begin
            r_mem[r_bank_sel][r_count] <= Pixel_In;
        end
    end

    assign w_rd_bank      = ~r_bank_sel;
    assign w_sel_in_range = ({1'b0, PixelX_Select} < DEPTH_EXT);

    always_comb begin
        Pixel_Out = '0;
        if (w_sel_in_range) begin
            Pixel_Out = r_mem[w_rd_bank][PixelX_Select];
        end
    end

    assign Pixel_In_Ready = (r_load_state == LD_FILL);
    assign Compute_Busy   = (r_comp_state == CP_BUSY);
    assign Input_Valid    = r_input_valid;
    assign Bank_Sel       = r_bank_sel;

endmodule
